// File: rtl/sbox_array.sv
// ============================================================================
// Module      : sbox_array
// Description : LANES-wide AES S-box substitution pipeline (1 or 2 stages)
//               with valid/ready handshake. Define SBOX_ARRAY_INV_EN to add
//               the per-word inverse S-box selected by in_inv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_array #(
    parameter int LANES  = 4,
    parameter int STAGES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);

    localparam int W = 8 * LANES;

    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
        logic [7:0] b;
        b = gf_inv(v);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

`ifdef SBOX_ARRAY_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] v);
        return gf_inv(rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05);
    endfunction
`endif

    logic [W-1:0] sub_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef SBOX_ARRAY_INV_EN
        assign sub_d[8*k +: 8] = in_inv ? inv_sbox(in_data[8*k +: 8])
                                        : fwd_sbox(in_data[8*k +: 8]);
`else
        assign sub_d[8*k +: 8] = fwd_sbox(in_data[8*k +: 8]);
`endif
    end

`ifndef SBOX_ARRAY_INV_EN
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_data_q,  s1_data_d;
    logic         s1_adv;
    logic         s1_load;

    assign in_ready = !s1_valid_q || s1_adv;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_data_d  = sub_d;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (STAGES == 2) begin : g_two
        logic         s2_valid_q, s2_valid_d;
        logic [W-1:0] s2_data_q,  s2_data_d;

        assign s1_adv = !s2_valid_q || out_ready;

        // Stage 2 is a plain retiming register for the stage-1 lookup result
        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_data_d  = s2_data_q;
            if (s1_valid_q && s1_adv) begin
                s2_valid_d = 1'b1;
                s2_data_d  = s1_data_q;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign out_valid = s2_valid_q;
        assign out_data  = s2_data_q;
    end else begin : g_one
        assign s1_adv    = out_ready;
        assign out_valid = s1_valid_q;
        assign out_data  = s1_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sbox_array.sv
// ============================================================================
// Module      : tb_sbox_array
// Description : Bench for sbox_array, one instance per STAGES value (1 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sbox_array;

    localparam int LANES = 4;
`ifdef SBOX_ARRAY_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [7:0] FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] inv_tab [256];

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_inv;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a  [2];
    logic        out_valid_a [2];
    logic [31:0] out_data_a  [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < LANES; k++)
            r[8*k +: 8] = (inv && INV_EN) ? inv_tab[d[8*k +: 8]] : FWD[d[8*k +: 8]];
        return r;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          age;
    } ent_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int ST = g + 1;
        ent_t sb [$];
        bit   exp_v;
        bit   exp_rdy;

        sbox_array #(.LANES(LANES), .STAGES(ST)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[g]),
            .in_inv    (in_inv),
            .in_data   (in_data),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .out_data  (out_data_a[g])
        );

        // Front word is visible once it has seen ST edges; queue depth sets in_ready
        always @(negedge clk) begin
            if (!reset) begin
                check($sformatf("s%0d_rst_out_valid", ST), 32'(out_valid_a[g]), 32'd0);
                check($sformatf("s%0d_rst_out_data", ST), out_data_a[g], 32'd0);
                check($sformatf("s%0d_rst_in_ready", ST), 32'(in_ready_a[g]), 32'd1);
                sb.delete();
            end else begin
                exp_v   = (sb.size() > 0) && (sb[0].age >= ST);
                exp_rdy = (sb.size() < ST) || out_ready;
                check($sformatf("s%0d_out_valid", ST), 32'(out_valid_a[g]), 32'(exp_v));
                check($sformatf("s%0d_in_ready", ST), 32'(in_ready_a[g]), 32'(exp_rdy));
                if (exp_v)
                    check($sformatf("s%0d_out_data", ST), out_data_a[g], sb[0].data);
                if (exp_v && out_ready)
                    void'(sb.pop_front());
                foreach (sb[i]) sb[i].age++;
                if (in_valid && exp_rdy)
                    sb.push_back('{exp_word(in_data, in_inv), 1});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic inv, input logic [31:0] d, input logic rdy);
        in_valid  = v;
        in_inv    = inv;
        in_data   = d;
        out_ready = rdy;
    endtask

    logic [31:0] words [3];
    logic [7:0]  b;

    initial begin
        for (int i = 0; i < 256; i++) inv_tab[FWD[i]] = 8'(i);
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // Spec reference words
        drive(1'b1, 1'b0, 32'hFF80_5300, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("ref_fwd_valid", 32'(out_valid_a[0]), 32'd1);
        check("ref_fwd_data", out_data_a[0], 32'h16CD_ED63);
        repeat (3) cyc();

        drive(1'b1, 1'b1, 32'h1600_ED63, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("ref_inv_data", out_data_a[0], INV_EN ? 32'hFF52_5300 : 32'h4763_55FB);
        repeat (3) cyc();

        // Back-to-back A, B, C on the two-stage instance
        words[0] = 32'h0123_4567;
        words[1] = 32'h89AB_CDEF;
        words[2] = 32'hF0E1_D2C3;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 1'b0, words[i], 1'b1);
            else       drive(1'b0, 1'b0, 32'h0, 1'b1);
            cyc();
            if (i >= 1 && i <= 3) begin
                check("b2b_valid", 32'(out_valid_a[1]), 32'd1);
                check("b2b_data", out_data_a[1], exp_word(words[i-1], 1'b0));
            end
        end

        // Stall: out_ready low for five cycles with input offered
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'(i & 1), $urandom, 1'b0);
            cyc();
        end
        check("stall_in_ready_s1", 32'(in_ready_a[0]), 32'd0);
        check("stall_in_ready_s2", 32'(in_ready_a[1]), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cyc();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom), $urandom,
                  1'($urandom_range(0, 9) < 7));
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cyc();

        // Every byte value on every lane, both modes
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                b = 8'(v);
                drive(1'b1, 1'(m), {b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b1);
                cyc();
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cyc();

        // Reset with two words in flight
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, $urandom, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_valid_s2", 32'(out_valid_a[1]), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_valid_s1", 32'(out_valid_a[0]), 32'd0);
        check("async_rst_valid_s2", 32'(out_valid_a[1]), 32'd0);
        check("async_rst_data_s2", out_data_a[1], 32'd0);
        check("async_rst_ready_s2", 32'(in_ready_a[1]), 32'd1);
        repeat (2) cyc();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("post_rst_idle_s2", 32'(out_valid_a[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sbox_array.md
SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel byte lanes, legal 1..16.
REQ-002 SHALL have parameter STAGES, default 1, register stages from input to output, legal 1 or 2.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, input word present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts the input word this cycle.
REQ-007 SHALL have port in_inv, input, 1 bit, 1 = inverse S-box for this word, 0 = forward S-box.
REQ-008 SHALL have port in_data, input, 8*LANES bits; lane k occupies bits [8k+7:8k].
REQ-009 SHALL have port out_valid, output, 1 bit, output word present.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts the output word.
REQ-011 SHALL have port out_data, output, 8*LANES bits, substituted bytes in the same lane order as in_data.

Function
REQ-012 SHALL substitute each lane independently with the FIPS-197 S-box (forward) or inverse S-box, for all 256 byte values including 0x80-0xFF; no value is masked or forced.
REQ-013 SHALL capture an input word on a rising edge only when in_valid and in_ready are both 1; in_inv is captured with the data and applies to that word only.
REQ-014 SHALL deliver a word downstream only when out_valid and out_ready are both 1.
REQ-015 SHALL give a latency of exactly STAGES cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-016 SHALL hold one valid flag per stage; a stage loads when it is empty or its contents are advancing on the same edge.
REQ-017 SHALL drive in_ready = NOT stage1_valid OR stage1_advances, computed combinationally, so the block sustains one word per cycle with out_ready held at 1.
REQ-018 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0; no word is dropped or duplicated.
REQ-019 SHALL, with STAGES=2, perform the table lookup in stage 1 and register the result unchanged in stage 2.
REQ-020 SHALL, when a word is accepted on the same edge the output word leaves, load the new word with no bubble.
REQ-021 SHALL ignore in_data and in_inv when in_valid=0 and leave stage registers unchanged.

Reset
REQ-022 SHALL, while reset=0, immediately force all stage valid flags to 0, out_valid to 0, out_data to 0, and in_ready to 1 once the flags are clear.
REQ-023 SHALL discard in-flight words on reset asserted mid-operation; no word emerges after reset release unless newly accepted.
REQ-024 SHALL resume normal operation on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with macro SBOX_ARRAY_INV_EN defined, implement the inverse table and select it per word through in_inv.
REQ-026 SHALL, without SBOX_ARRAY_INV_EN, omit the inverse table, ignore in_inv and apply the forward table to every word; the port list is unchanged.

Verification
REQ-027 SHALL be verified with LANES=4, STAGES=1: in_data=0xFF80_5300, in_inv=0, out_ready=1 -> out_data=0x16CD_ED63 with out_valid one cycle after acceptance.
REQ-028 SHALL be verified with SBOX_ARRAY_INV_EN defined: in_data=0x1600_ED63, in_inv=1 -> out_data=0xFF52_5300; with the macro undefined, the same stimulus -> 0x4763_55FB.
REQ-029 SHALL be verified with STAGES=2 under back-to-back input: words A, B, C on consecutive cycles with out_ready=1 -> outputs A, B, C on cycles 2, 3 and 4 after A's acceptance, with no bubbles.
REQ-030 SHALL be verified with out_ready held at 0 for 5 cycles while in_valid=1 -> in_ready drops after STAGES words are held; out_data stays stable; releasing out_ready delivers all words in order.
REQ-031 SHALL be verified with reset pulsed low while 2 words are in flight (STAGES=2) -> out_valid=0 and out_data=0 immediately; no stale word appears after release.
REQ-032 SHALL be verified with an exhaustive sweep of all 256 byte values on every lane, in both modes -> out_data matches the FIPS-197 tables byte for byte.
